// File: rtl/rf_seq_pkg.sv
// Shared types and constants for the accumulate-loop sequencer and its datapath.
package rf_seq_pkg;

    typedef enum logic [8:0] {
        S_IDLE     = 9'b000000001,
        S_INIT_I   = 9'b000000010,
        S_INIT_SUM = 9'b000000100,
        S_INIT_ONE = 9'b000001000,
        S_CHECK    = 9'b000010000,
        S_ADD      = 9'b000100000,
        S_INC      = 9'b001000000,
        S_OUT      = 9'b010000000,
        S_DONE     = 9'b100000000
    } state_e;

    localparam int REG_ZERO = 0;
    localparam int REG_I    = 1;
    localparam int REG_SUM  = 2;
    localparam int REG_ONE  = 3;

    localparam logic [1:0] ALU_ADD = 2'b00;

    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_IMM = 1'b1;

endpackage

// File: rtl/rf_seq_iter_counter.sv
// Loop-iteration watchdog counter: clears on run start, saturates at MAX_ITER.
module rf_seq_iter_counter #(
    parameter int DATA_W   = 8,
    parameter int MAX_ITER = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic at_limit
);

    localparam logic [DATA_W-1:0] LIMIT = DATA_W'(MAX_ITER);

    logic [DATA_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (inc && count_q != LIMIT)
            count_d = count_q + DATA_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign at_limit = (count_q == LIMIT);

endmodule

// File: rtl/rf_loop_sequencer.sv
// Control unit driving the register-file datapath through i=0, sum=0, sum+=i, i+=1
// while i <= bound, with start/busy/done handshake and an iteration watchdog.
module rf_loop_sequencer
    import rf_seq_pkg::*;
#(
    parameter int RF_ADDR_W = 3,
    parameter int DATA_W    = 8,
    parameter int MAX_ITER  = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 iLeBound,
    output logic                 rfsrcmuxsel,
    output logic [DATA_W-1:0]    imm,
    output logic                 rfwe,
    output logic [RF_ADDR_W-1:0] waddr,
    output logic [RF_ADDR_W-1:0] raddr1,
    output logic [RF_ADDR_W-1:0] raddr2,
    output logic [1:0]           alu_sel,
    output logic                 outLoad,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    state_e state_q, state_d;

    logic                 src_q, src_d;
    logic [DATA_W-1:0]    imm_q, imm_d;
    logic                 rfwe_q, rfwe_d;
    logic [RF_ADDR_W-1:0] waddr_q, waddr_d;
    logic [RF_ADDR_W-1:0] raddr1_q, raddr1_d;
    logic [RF_ADDR_W-1:0] raddr2_q, raddr2_d;
    logic [1:0]           alu_q, alu_d;
    logic                 out_load_q, out_load_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic cnt_clr, cnt_inc, at_limit;

    rf_seq_iter_counter #(
        .DATA_W   (DATA_W),
        .MAX_ITER (MAX_ITER)
    ) u_iter_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (cnt_clr),
        .inc      (cnt_inc),
        .at_limit (at_limit)
    );

    assign cnt_inc = (state_q == S_ADD);

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        cnt_clr = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_INIT_I;
                    err_d   = 1'b0;
                    cnt_clr = 1'b1;
                end
            end
            S_INIT_I:   state_d = S_INIT_SUM;
            S_INIT_SUM: state_d = S_INIT_ONE;
            S_INIT_ONE: state_d = S_CHECK;
            S_CHECK: begin
                if (!iLeBound) begin
                    state_d = S_OUT;
                end else if (at_limit) begin
                    state_d = S_OUT;
                    err_d   = 1'b1;
                end else begin
                    state_d = S_ADD;
                end
            end
            S_ADD:   state_d = S_INC;
            S_INC:   state_d = S_CHECK;
            S_OUT:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they line up
    // with the state they belong to without any input-to-output path.
    always_comb begin
        src_d      = SRC_ALU;
        imm_d      = '0;
        rfwe_d     = 1'b0;
        waddr_d    = '0;
        raddr1_d   = '0;
        raddr2_d   = '0;
        alu_d      = ALU_ADD;
        out_load_d = 1'b0;
        done_d     = 1'b0;
        busy_d     = (state_d != S_IDLE);
        case (state_d)
            S_INIT_I: begin
                rfwe_d  = 1'b1;
                src_d   = SRC_IMM;
                waddr_d = RF_ADDR_W'(REG_I);
            end
            S_INIT_SUM: begin
                rfwe_d  = 1'b1;
                src_d   = SRC_IMM;
                waddr_d = RF_ADDR_W'(REG_SUM);
            end
            S_INIT_ONE: begin
                rfwe_d  = 1'b1;
                src_d   = SRC_IMM;
                imm_d   = DATA_W'(1);
                waddr_d = RF_ADDR_W'(REG_ONE);
            end
            S_CHECK: raddr1_d = RF_ADDR_W'(REG_I);
            S_ADD: begin
                raddr1_d = RF_ADDR_W'(REG_SUM);
                raddr2_d = RF_ADDR_W'(REG_I);
                rfwe_d   = 1'b1;
                waddr_d  = RF_ADDR_W'(REG_SUM);
            end
            S_INC: begin
                raddr1_d = RF_ADDR_W'(REG_I);
                raddr2_d = RF_ADDR_W'(REG_ONE);
                rfwe_d   = 1'b1;
                waddr_d  = RF_ADDR_W'(REG_I);
            end
            S_OUT: begin
                raddr1_d   = RF_ADDR_W'(REG_SUM);
                out_load_d = 1'b1;
            end
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            src_q      <= 1'b0;
            imm_q      <= '0;
            rfwe_q     <= 1'b0;
            waddr_q    <= '0;
            raddr1_q   <= '0;
            raddr2_q   <= '0;
            alu_q      <= '0;
            out_load_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            imm_q      <= imm_d;
            rfwe_q     <= rfwe_d;
            waddr_q    <= waddr_d;
            raddr1_q   <= raddr1_d;
            raddr2_q   <= raddr2_d;
            alu_q      <= alu_d;
            out_load_q <= out_load_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign rfsrcmuxsel = src_q;
    assign imm         = imm_q;
    assign rfwe        = rfwe_q;
    assign waddr       = waddr_q;
    assign raddr1      = raddr1_q;
    assign raddr2      = raddr2_q;
    assign alu_sel     = alu_q;
    assign outLoad     = out_load_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_rf_loop_sequencer.sv
// Sequencer bench: datapath model in the loop, cycle-indexed reference for every output.
module tb_rf_loop_sequencer;

    localparam int MAXI = 12;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       iLeBound;
    logic       rfsrcmuxsel;
    logic [7:0] imm;
    logic       rfwe;
    logic [2:0] waddr, raddr1, raddr2;
    logic [1:0] alu_sel;
    logic       outLoad, busy, done, err;

    rf_loop_sequencer #(.RF_ADDR_W(3), .DATA_W(8), .MAX_ITER(MAXI)) dut (
        .clk(clk), .reset(rst_n), .start(start), .iLeBound(iLeBound),
        .rfsrcmuxsel(rfsrcmuxsel), .imm(imm), .rfwe(rfwe), .waddr(waddr),
        .raddr1(raddr1), .raddr2(raddr2), .alu_sel(alu_sel), .outLoad(outLoad),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic chk_on = 1'b0;

    // ---------------- datapath model ----------------
    logic [7:0] rf [8] = '{default: 8'd0};
    logic [7:0] outport = 8'd0;
    logic [7:0] bound = 8'd10;
    logic       force_le = 1'b0;
    int add_cnt = 0, inc_cnt = 0, one_cnt = 0;

    assign iLeBound = force_le | (rf[raddr1] <= bound);

    always @(posedge clk) begin
        if (rfwe && waddr != 3'd0)
            rf[waddr] <= rfsrcmuxsel ? imm : rf[raddr1] + rf[raddr2];
        if (outLoad) outport <= rf[raddr1];
        if (rfwe && waddr == 3'd2 && !rfsrcmuxsel) add_cnt <= add_cnt + 1;
        if (rfwe && waddr == 3'd1 && !rfsrcmuxsel) inc_cnt <= inc_cnt + 1;
        if (rfwe && waddr == 3'd3 && rfsrcmuxsel && imm == 8'd1) one_cnt <= one_cnt + 1;
    end

    // ---------------- reference model ----------------
    // A run with N iterations is a fixed timeline relative to its accept edge:
    // 3 init cycles, N x (CHECK,ADD,INC), final CHECK, OUT, DONE.
    logic       m_active, m_trip, m_err;
    int         m_cyc, m_n;
    logic [7:0] m_sum;

    function automatic int iters(logic [7:0] b, logic f);
        if (f) return MAXI;
        return (int'(b) + 1 < MAXI) ? int'(b) + 1 : MAXI;
    endfunction

    function automatic logic [7:0] tri_sum(int n);
        return 8'((n * (n - 1) / 2) % 256);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_err    <= 1'b0;
            m_cyc    <= 0;
            m_n      <= 0;
            m_trip   <= 1'b0;
            m_sum    <= 8'd0;
        end else if (!m_active) begin
            if (start) begin
                m_active <= 1'b1;
                m_cyc    <= 0;
                m_err    <= 1'b0;
                m_n      <= iters(bound, force_le);
                m_trip   <= force_le || (int'(bound) + 1 > MAXI);
                m_sum    <= tri_sum(iters(bound, force_le));
            end
        end else if (m_cyc == 3 * m_n + 5) begin
            m_active <= 1'b0;
        end else begin
            m_cyc <= m_cyc + 1;
            if (m_cyc + 1 == 3 * m_n + 4 && m_trip) m_err <= 1'b1;
        end
    end

    function automatic logic [24:0] exp_vec(logic act, int c, int n, logic e);
        logic       src, we, ol, dn;
        logic [7:0] im;
        logic [2:0] wa, r1, r2;
        src = 1'b0; we = 1'b0; ol = 1'b0; dn = 1'b0;
        im = 8'd0; wa = 3'd0; r1 = 3'd0; r2 = 3'd0;
        if (act) begin
            if (c < 3) begin
                we = 1'b1; src = 1'b1; wa = 3'(c + 1); im = (c == 2) ? 8'd1 : 8'd0;
            end else if (c < 3 + 3 * n) begin
                case ((c - 3) % 3)
                    0: r1 = 3'd1;
                    1: begin r1 = 3'd2; r2 = 3'd1; we = 1'b1; wa = 3'd2; end
                    default: begin r1 = 3'd1; r2 = 3'd3; we = 1'b1; wa = 3'd1; end
                endcase
            end else if (c == 3 + 3 * n) begin
                r1 = 3'd1;
            end else if (c == 4 + 3 * n) begin
                r1 = 3'd2; ol = 1'b1;
            end else begin
                dn = 1'b1;
            end
        end
        return {src, im, we, wa, r1, r2, 2'b00, ol, act, dn, e};
    endfunction

    logic [24:0] act_vec;
    assign act_vec = {rfsrcmuxsel, imm, rfwe, waddr, raddr1, raddr2, alu_sel, outLoad, busy, done, err};

    always @(negedge clk) begin
        if (rst_n && chk_on) begin
            tests++;
            if (act_vec !== exp_vec(m_active, m_cyc, m_n, m_err)) begin
                fails++;
                $display("FAIL cycle_outputs t=%0t got=%h exp=%h", $time, act_vec,
                         exp_vec(m_active, m_cyc, m_n, m_err));
            end
            if (done && m_active) begin
                tests++;
                if (outport !== m_sum) begin
                    fails++;
                    $display("FAIL outport_at_done t=%0t got=%0d exp=%0d", $time, outport, m_sum);
                end
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d", name, act, expv);
        end
    endtask

    // Pulses (or holds) start in an IDLE cycle; k=0 is the INIT_I cycle.
    task automatic run_watch(input logic hold, output int done_at, output int ol_at,
                             output int adds, output int incs, output int ones,
                             output int err0);
        int a0, i0, o0;
        @(negedge clk);
        a0 = add_cnt; i0 = inc_cnt; o0 = one_cnt;
        done_at = -1; ol_at = -1;
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        err0 = int'(err);
        for (int k = 0; k < 500; k++) begin
            if (outLoad && ol_at < 0) ol_at = k;
            if (done) begin
                done_at = k;
                break;
            end
            @(negedge clk);
        end
        adds = add_cnt - a0; incs = inc_cnt - i0; ones = one_cnt - o0;
    endtask

    int d_at, o_at, na, ni, no, e0;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs_zero", int'(act_vec), 0);
        rst_n = 1'b1;
        chk_on = 1'b1;

        // bound 10: 11 iterations, sum 55
        bound = 8'd10; force_le = 1'b0;
        run_watch(1'b0, d_at, o_at, na, ni, no, e0);
        chk("b10_done_cycle", d_at, 38);
        chk("b10_outload_cycle", o_at, 37);
        chk("b10_outport", int'(outport), 55);
        chk("b10_err", int'(err), 0);
        chk("b10_add_writes", na, 11);
        chk("b10_inc_writes", ni, 11);
        chk("b10_r3_writes", no, 1);

        // bound 0: single iteration
        bound = 8'd0;
        run_watch(1'b0, d_at, o_at, na, ni, no, e0);
        chk("b0_done_cycle", d_at, 8);
        chk("b0_outport", int'(outport), 0);
        chk("b0_add_writes", na, 1);

        // watchdog: comparison flag stuck high
        bound = 8'd3; force_le = 1'b1;
        run_watch(1'b0, d_at, o_at, na, ni, no, e0);
        chk("wd_done_cycle", d_at, 3 + 3 * MAXI + 2);
        chk("wd_add_writes", na, MAXI);
        chk("wd_err_at_done", int'(err), 1);
        chk("wd_outport", int'(outport), 66);
        repeat (3) @(negedge clk);
        chk("wd_err_sticky", int'(err), 1);
        chk("wd_idle_busy", int'(busy), 0);

        // next start clears err
        force_le = 1'b0; bound = 8'd2;
        run_watch(1'b0, d_at, o_at, na, ni, no, e0);
        chk("err_cleared_on_start", e0, 0);
        chk("b2_done_cycle", d_at, 14);
        chk("b2_outport", int'(outport), 3);

        // start held high: back-to-back run after one IDLE cycle
        bound = 8'd10;
        run_watch(1'b1, d_at, o_at, na, ni, no, e0);
        chk("hold_done_cycle", d_at, 38);
        @(negedge clk);
        chk("hold_idle_busy", int'(busy), 0);
        @(negedge clk);
        chk("hold_restart_init_i", int'({busy, rfwe, waddr}), 5'b11001);
        start = 1'b0;
        for (int k = 0; k < 100 && !done; k++) @(negedge clk);
        chk("hold_second_done", int'(done), 1);

        // reset asserted mid-ADD
        run_watch(1'b0, d_at, o_at, na, ni, no, e0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_reset_in_add", int'({rfwe, waddr, rfsrcmuxsel}), 5'b10100);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_zero", int'(act_vec), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_reset_busy", int'(busy), 0);
        chk("post_reset_done", int'(done), 0);

        // random traffic, start toggled freely including while busy
        for (int c = 0; c < 1500; c++) begin
            if (!m_active && $urandom_range(0, 3) == 0) begin
                bound    = ($urandom_range(0, 9) == 0) ? 8'd255 : 8'($urandom_range(0, 16));
                force_le = ($urandom_range(0, 5) == 0);
            end
            start = ($urandom_range(0, 2) == 0);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (60) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
